// File: rtl/rng_stream_pkg.sv
// Shared types and constants for the RNG stream buffer: bus FSM states and
// fixed Wishbone field values.
package rng_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [31:0] RNG_ADR_DEFAULT = 32'd0;
    localparam logic [3:0]  SEL_ALL         = 4'hF;

endpackage

// File: rtl/rng_sync_fifo.sv
// First-word-fall-through FIFO: head word is visible combinationally while
// level is non-zero. Pushes into a full FIFO and pops from an empty one are ignored.
module rng_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok   = push && (level_reg != LW'(DEPTH));
    assign pop_ok    = pop && (level_reg != '0);
    assign head_data = mem[rd_ptr_reg];
    assign level     = level_reg;

    // Storage is deliberately left out of reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/rng_stream_buffer.sv
// Wishbone read master that prefetches random words from an RNG slave into a
// FWFT FIFO and presents them as a valid/ready stream.
module rng_stream_buffer
    import rng_stream_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter int          TIMEOUT = 15,
    parameter logic [31:0] RNG_ADR = RNG_ADR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   m_cyc,
    output logic                   m_stb,
    output logic                   m_we,
    output logic [3:0]             m_sel,
    output logic [31:0]            m_adr,
    output logic [31:0]            m_dat_w,
    input  logic [31:0]            m_dat_r,
    input  logic                   m_ack,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout_err,
    input  logic                   clr_err
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_reg;
    state_t        state_next;
    logic [TW-1:0] timer_reg;
    logic          err_reg;
    logic          push;
    logic          abort;
    logic [LW-1:0] fifo_level;

    assign push  = (state_reg == REQ) && m_ack;
    assign abort = (state_reg == REQ) && !m_ack && (timer_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Timer only runs inside REQ, so it is already zero on every REQ entry.
            if (state_reg != REQ) begin
                timer_reg <= '0;
            end else if (!m_ack) begin
                timer_reg <= timer_reg + TW'(1);
            end
            if (abort) begin
                err_reg <= 1'b1;
            end else if (clr_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        m_cyc      = 1'b0;
        m_stb      = 1'b0;
        m_we       = 1'b0;
        m_sel      = 4'h0;
        m_adr      = 32'd0;
        m_dat_w    = 32'd0;
        case (state_reg)
            IDLE: begin
                // Space is reserved at request start, so the push can never overflow.
                if (enable && (fifo_level < LW'(DEPTH))) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                m_sel = SEL_ALL;
                m_adr = RNG_ADR;
                if (m_ack || abort) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    rng_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (m_dat_r),
        .pop       (out_ready),
        .head_data (out_data),
        .level     (fifo_level)
    );

    assign level       = fifo_level;
    assign out_valid   = (fifo_level != '0);
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_rng_stream_buffer.sv
// Directed bench for rng_stream_buffer: cycle table for the fill phase, a
// scoreboard on popped words, and hand sequences for timeout and reset cases.
module tb_rng_stream_buffer;

    localparam logic [31:0] ADR  = 32'h4000_0010;
    localparam logic [31:0] BASE = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat_w, m_dat_r;
    logic        m_ack;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  level;
    logic        timeout_err;
    logic        clr_err = 1'b0;

    logic        noack = 1'b0;
    logic        ack_r = 1'b0;
    logic [31:0] slave_word = BASE;
    logic [31:0] exp_q[$];
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          pop_cnt = 0;

    typedef struct {
        int         cyc;
        logic       stb;
        logic [3:0] lvl;
        logic       valid;
    } row_t;
    row_t tbl[13];

    always #5 clk = ~clk;

    rng_stream_buffer #(.DEPTH(8), .TIMEOUT(15), .RNG_ADR(ADR)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    // RNG slave: registered ack one cycle after cyc&stb, incrementing data words.
    assign m_ack   = ack_r;
    assign m_dat_r = slave_word;
    always @(posedge clk) begin
        if (m_cyc && m_stb && ack_r) begin
            exp_q.push_back(slave_word);
            slave_word <= slave_word + 32'd1;
        end
        ack_r <= m_cyc && m_stb && !ack_r && !noack;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word must be the oldest word the slave delivered.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        #1;
        if (rst_n && out_valid && out_ready) begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("sb_word", out_data, exp_w);
            pop_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cur;
        int  cnt;
        bit  hit;
        logic [3:0] lvl0;

        tbl[0]  = '{0,  1'b0, 4'd0, 1'b0};
        tbl[1]  = '{1,  1'b1, 4'd0, 1'b0};
        tbl[2]  = '{2,  1'b1, 4'd0, 1'b0};
        tbl[3]  = '{3,  1'b0, 4'd1, 1'b1};
        tbl[4]  = '{4,  1'b0, 4'd1, 1'b1};
        tbl[5]  = '{5,  1'b1, 4'd1, 1'b1};
        tbl[6]  = '{7,  1'b0, 4'd2, 1'b1};
        tbl[7]  = '{11, 1'b0, 4'd3, 1'b1};
        tbl[8]  = '{27, 1'b0, 4'd7, 1'b1};
        tbl[9]  = '{29, 1'b1, 4'd7, 1'b1};
        tbl[10] = '{31, 1'b0, 4'd8, 1'b1};
        tbl[11] = '{32, 1'b0, 4'd8, 1'b1};
        tbl[12] = '{40, 1'b0, 4'd8, 1'b1};

        // Reset state
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cyc", m_cyc, 0);
        check("rst_stb", m_stb, 0);
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_err", timeout_err, 0);

        // Fill from empty with the consumer stalled
        rst_n = 1'b1;
        cur = 0;
        for (int i = 0; i < 13; i++) begin
            while (cur < tbl[i].cyc) begin
                @(negedge clk);
                cur++;
            end
            check($sformatf("c%0d_stb", tbl[i].cyc), m_stb, tbl[i].stb);
            check($sformatf("c%0d_cyc", tbl[i].cyc), m_cyc, tbl[i].stb);
            check($sformatf("c%0d_sel", tbl[i].cyc), m_sel, tbl[i].stb ? 4'hF : 4'h0);
            check($sformatf("c%0d_adr", tbl[i].cyc), m_adr, tbl[i].stb ? ADR : 32'd0);
            check($sformatf("c%0d_we", tbl[i].cyc), {m_we, m_dat_w}, 0);
            check($sformatf("c%0d_level", tbl[i].cyc), level, tbl[i].lvl);
            check($sformatf("c%0d_valid", tbl[i].cyc), out_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                check($sformatf("c%0d_data", tbl[i].cyc), out_data, BASE);
            end
        end

        // Drain from full with out_ready held: refetch starts the cycle after level<8
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_level7", level, 7);
        check("drain_stb_wait", m_stb, 0);
        @(negedge clk);
        check("drain_refetch", m_stb, 1);
        repeat (90) @(negedge clk);
        enable = 1'b0;
        repeat (12) @(negedge clk);
        check("drain_empty", level, 0);
        check("drain_sb_empty", exp_q.size(), 0);
        check("drain_wrap20", (pop_cnt >= 20) ? 1 : 0, 1);
        out_ready = 1'b0;

        // Simultaneous push and pop at level 3
        enable = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            if (level == 4'd3 && m_ack) hit = 1'b1;
        end
        check("pp_reach", hit, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        enable = 1'b0;
        check("pp_level", level, 3);
        repeat (4) @(negedge clk);

        // Dropping enable in REQ lets the transaction finish, then no more fetches
        lvl0 = level;
        enable = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (m_stb) hit = 1'b1;
        end
        check("en_req", hit, 1);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("en_done", level, lvl0 + 4'd1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_stb) cnt++;
        end
        check("en_no_stb", cnt, 0);

        // Reset in the second REQ cycle drops the word
        enable = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (m_stb) hit = 1'b1;
        end
        check("mid_req", hit, 1);
        @(posedge clk);
        #1;
        check("mid_ack", m_ack, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_cyc", m_cyc, 0);
        check("mid_level", level, 0);
        check("mid_valid", out_valid, 0);
        @(negedge clk);
        check("mid_nopush", level, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("resume_stb", m_stb, 1);

        // Timeout with a silent slave
        @(negedge clk);
        rst_n = 1'b0;
        noack = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (m_stb) cnt++;
        end
        check("to_stb_cycles", cnt, 15);
        check("to_err", timeout_err, 1);
        check("to_nopush", level, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("to_sticky", timeout_err, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_clear", timeout_err, 0);

        // clr_err coinciding with a second timeout: set wins
        enable = 1'b1;
        cnt = 0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (m_stb) cnt++;
            if (cnt == 15) hit = 1'b1;
        end
        check("to2_reach", hit, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        enable = 1'b0;
        check("to2_set_wins", timeout_err, 1);
        check("to2_bus_idle", m_stb, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
